// File: rtl/instruction_fetch_stage.sv
// ---------------------------------------------------------------------------
// instruction_fetch_stage
//
// IF stage of a 5-stage MIPS pipeline. Owns the program counter, presents it
// as the byte address to a combinational instruction memory, and captures the
// returned word into the IF/ID pipeline register. Handles stall, flush and
// branch/jump redirects, including redirects that arrive while stalled (these
// are latched in the PEND state and applied when the stall releases).
//
// Optional feature macro: IF_DELAY_SLOT_EN
//   defined   : MIPS branch-delay-slot semantics; the word fetched on the
//               edge a redirect is applied is captured as a real instruction.
//   undefined : that word is squashed into a bubble (NOP_INSTR, Valid=0).
//
// Parameters
//   RESET_PC   PC loaded on reset (word aligned)
//   NOP_INSTR  bubble word written into IF/ID on flush/squash
//
// Ports
//   Clk              in   1   clock, rising edge
//   Reset_n          in   1   asynchronous active-low reset
//   Stall            in   1   hold PC and IF/ID
//   Flush            in   1   insert bubble into IF/ID
//   BranchTaken      in   1   redirect request (1-cycle pulse)
//   BranchTarget     in   32  redirect byte address
//   IMemAddress      out  32  byte address to instruction memory (= PC)
//   IMemInstruction  in   32  word returned by instruction memory
//   IFID_Instruction out  32  registered instruction
//   IFID_PCPlus4     out  32  registered PC+4 of that instruction
//   IFID_Valid       out  1   1 = real instruction, 0 = bubble
// ---------------------------------------------------------------------------
module instruction_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    output logic [31:0] IMemAddress,
    input  logic [31:0] IMemInstruction,
    output logic [31:0] IFID_Instruction,
    output logic [31:0] IFID_PCPlus4,
    output logic        IFID_Valid
);

`ifdef IF_DELAY_SLOT_EN
    localparam bit SQUASH_ON_REDIRECT = 1'b0;
`else
    localparam bit SQUASH_ON_REDIRECT = 1'b1;
`endif

    typedef enum logic {
        S_RUN  = 1'b0,
        S_PEND = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] tgt_q, tgt_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        vld_q, vld_d;

    logic [31:0] pc_plus4;
    logic [31:0] br_tgt_aligned;
    logic        redirect_now;

    // Masking (rather than slicing) keeps every BranchTarget bit in use.
    assign br_tgt_aligned = BranchTarget & ~32'h3;
    assign pc_plus4       = pc_q + 32'd4;   // wraps modulo 2^32

    // A redirect takes effect on any unstalled edge with a fresh request or a
    // latched one waiting in PEND.
    assign redirect_now = !Stall && (BranchTaken || (state_q == S_PEND));

    // ---------------- state register ----------------
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_RUN;
            pc_q    <= RESET_PC;
            tgt_q   <= 32'h0;
            instr_q <= NOP_INSTR;
            pc4_q   <= 32'h0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            vld_q   <= vld_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_RUN:  if (Stall && BranchTaken) state_d = S_PEND;
            S_PEND: if (!Stall)               state_d = S_RUN;
            default:                          state_d = S_RUN;
        endcase
    end

    // ---------------- datapath / output logic ----------------
    always_comb begin
        pc_d    = pc_q;
        tgt_d   = tgt_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        vld_d   = vld_q;

        // PC and pending target. Any request seen while stalled (re)loads the
        // latched target, so the latest one wins.
        if (Stall) begin
            if (BranchTaken) tgt_d = br_tgt_aligned;
        end else if (BranchTaken) begin
            pc_d = br_tgt_aligned;
        end else if (state_q == S_PEND) begin
            pc_d = tgt_q;
        end else begin
            pc_d = pc_plus4;
        end

        // IF/ID: Flush beats Stall beats capture.
        if (Flush) begin
            instr_d = NOP_INSTR;
            pc4_d   = 32'h0;
            vld_d   = 1'b0;
        end else if (!Stall) begin
            if (redirect_now && SQUASH_ON_REDIRECT) begin
                instr_d = NOP_INSTR;
                pc4_d   = 32'h0;
                vld_d   = 1'b0;
            end else begin
                instr_d = IMemInstruction;
                pc4_d   = pc_plus4;
                vld_d   = 1'b1;
            end
        end
    end

    assign IMemAddress      = pc_q;
    assign IFID_Instruction = instr_q;
    assign IFID_PCPlus4     = pc4_q;
    assign IFID_Valid       = vld_q;

endmodule
